// File: rtl/reg_rename_unit_v2_if.sv
// Decoder-to-ROB rename channel: instruction input, renamed packet output,
// commit port, flush and free-list occupancy.
interface reg_rename_unit_v2_if #(
  parameter int PHY_W     = 6,
  parameter int ARCH_W    = 5,
  parameter int ROB_IDX_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [ROB_IDX_W-1:0] in_rob_idx;
  logic                 in_dst_wen;
  logic [ARCH_W-1:0]    in_dst_arch;
  logic [ARCH_W-1:0]    in_src1_arch;
  logic [ARCH_W-1:0]    in_src2_arch;

  logic                 out_valid;
  logic                 out_ready;
  logic [ROB_IDX_W-1:0] out_rob_idx;
  logic                 out_dst_wen;
  logic [PHY_W-1:0]     out_dst_phy;
  logic [PHY_W-1:0]     out_prev_phy;
  logic [PHY_W-1:0]     out_src1_phy;
  logic [PHY_W-1:0]     out_src2_phy;

  logic                 commit_valid;
  logic                 commit_dst_wen;
  logic [ARCH_W-1:0]    commit_dst_arch;
  logic [PHY_W-1:0]     commit_dst_phy;
  logic [PHY_W-1:0]     commit_prev_phy;

  logic                 flush;
  logic [PHY_W:0]       free_count;

  modport master (
    output in_valid, in_rob_idx, in_dst_wen, in_dst_arch, in_src1_arch, in_src2_arch,
    output out_ready,
    output commit_valid, commit_dst_wen, commit_dst_arch, commit_dst_phy, commit_prev_phy,
    output flush,
    input  in_ready,
    input  out_valid, out_rob_idx, out_dst_wen, out_dst_phy, out_prev_phy,
    input  out_src1_phy, out_src2_phy,
    input  free_count
  );

  modport slave (
    input  in_valid, in_rob_idx, in_dst_wen, in_dst_arch, in_src1_arch, in_src2_arch,
    input  out_ready,
    input  commit_valid, commit_dst_wen, commit_dst_arch, commit_dst_phy, commit_prev_phy,
    input  flush,
    output in_ready,
    output out_valid, out_rob_idx, out_dst_wen, out_dst_phy, out_prev_phy,
    output out_src1_phy, out_src2_phy,
    output free_count
  );
endinterface

// File: rtl/reg_rename_unit_v2.sv
// Single-issue register rename stage: speculative RAT, committed CRAT and a
// circular free list with commit-point recovery on flush.
module reg_rename_unit_v2 #(
  parameter int NUM_PHYREG  = 64,
  parameter int NUM_ARCHREG = 32,
  parameter int ROB_IDX_W   = 5,
  parameter int ZERO_REG_EN = 1
) (
  input logic SIG_CLK,
  input logic SIG_RST,
  reg_rename_unit_v2_if.slave rn
);
  localparam int PHY_W     = $clog2(NUM_PHYREG);
  localparam int ARCH_W    = $clog2(NUM_ARCHREG);
  localparam int PTR_W     = PHY_W + 1;
  localparam int FREE_INIT = NUM_PHYREG - NUM_ARCHREG;

  typedef logic [PHY_W-1:0]                   phy_t;
  typedef logic [PTR_W-1:0]                   ptr_t;
  typedef logic [NUM_ARCHREG-1:0][PHY_W-1:0]  map_t;
  typedef logic [NUM_PHYREG-1:0][PHY_W-1:0]   flist_t;

  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < NUM_ARCHREG; i++) m[i] = phy_t'(i);
    return m;
  endfunction

  function automatic flist_t initial_free_list();
    flist_t f;
    for (int j = 0; j < NUM_PHYREG; j++)
      f[j] = (j < FREE_INIT) ? phy_t'(NUM_ARCHREG + j) : '0;
    return f;
  endfunction

  map_t   rat, crat, crat_next;
  flist_t fl;
  ptr_t   head, tail, commit_head, free_count;

  logic                 out_valid_q, out_dst_wen_q;
  logic [ROB_IDX_W-1:0] out_rob_idx_q;
  phy_t                 out_dst_phy_q, out_prev_phy_q, out_src1_phy_q, out_src2_phy_q;

  logic in_ready, accept, eff_wen, alloc, commit_fire;
  phy_t head_phy;

  assign free_count = tail - head;
  assign in_ready   = (free_count != '0) && (!out_valid_q || rn.out_ready) && !rn.flush;
  assign accept     = rn.in_valid && in_ready;
  assign eff_wen    = rn.in_dst_wen && !((ZERO_REG_EN != 0) && (rn.in_dst_arch == '0));
  assign alloc      = accept && eff_wen;
  assign head_phy   = fl[head[PHY_W-1:0]];

  assign commit_fire = rn.commit_valid && rn.commit_dst_wen &&
                       !((ZERO_REG_EN != 0) && (rn.commit_dst_arch == '0));

  // Committed map including this cycle's retirement; a flush restores from it.
  // NOTE: always_comb uses blocking '=' with a full default first, so no latch is inferred.
  always_comb begin
    crat_next = crat;
    if (commit_fire) crat_next[rn.commit_dst_arch] = rn.commit_dst_phy;
  end

  always_ff @(posedge SIG_CLK) begin
    if (SIG_RST) begin
      // NOTE: the map tables and free list are architectural state, so unlike
      // ordinary storage arrays they must be reset to known contents.
      rat            <= identity_map();
      crat           <= identity_map();
      fl             <= initial_free_list();
      head           <= '0;
      commit_head    <= '0;
      tail           <= ptr_t'(FREE_INIT);
      out_valid_q    <= 1'b0;
      out_rob_idx_q  <= '0;
      out_dst_wen_q  <= 1'b0;
      out_dst_phy_q  <= '0;
      out_prev_phy_q <= '0;
      out_src1_phy_q <= '0;
      out_src2_phy_q <= '0;
    end else begin
      // Retirement frees the old mapping even when a flush lands in the same cycle.
      if (commit_fire) begin
        crat                  <= crat_next;
        fl[tail[PHY_W-1:0]]   <= rn.commit_prev_phy;
        tail                  <= tail + ptr_t'(1);
        commit_head           <= commit_head + ptr_t'(1);
      end

      if (rn.flush) begin
        rat         <= crat_next;
        head        <= commit_head + ptr_t'(commit_fire);
        out_valid_q <= 1'b0;
      end else begin
        if (alloc) begin
          rat[rn.in_dst_arch] <= head_phy;
          head                <= head + ptr_t'(1);
        end

        if (accept) begin
          out_valid_q    <= 1'b1;
          out_rob_idx_q  <= rn.in_rob_idx;
          out_dst_wen_q  <= eff_wen;
          out_dst_phy_q  <= eff_wen ? head_phy : '0;
          out_prev_phy_q <= eff_wen ? rat[rn.in_dst_arch] : '0;
          out_src1_phy_q <= rat[rn.in_src1_arch];
          out_src2_phy_q <= rat[rn.in_src2_arch];
        end else if (rn.out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign rn.in_ready     = in_ready;
  assign rn.out_valid    = out_valid_q;
  assign rn.out_rob_idx  = out_rob_idx_q;
  assign rn.out_dst_wen  = out_dst_wen_q;
  assign rn.out_dst_phy  = out_dst_phy_q;
  assign rn.out_prev_phy = out_prev_phy_q;
  assign rn.out_src1_phy = out_src1_phy_q;
  assign rn.out_src2_phy = out_src2_phy_q;
  assign rn.free_count   = free_count;

  // Frees never outnumber earlier allocations, so the ring can never overfill.
  a_no_overflow: assert property (@(posedge SIG_CLK) disable iff (SIG_RST)
    free_count <= ptr_t'(NUM_PHYREG - 1));

endmodule
